// File: rtl/seg_frame_decoder_pkg.sv
// +--------------------------------------------------------------------+
// | seg_dec_pkg : shared types, blank code and digit table for the     |
// |               whack-a-mole segment-bus decoder                     |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package seg_dec_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } dec_state_e;

   typedef enum logic [1:0] {
      BLANK   = 2'd0,
      MOLE    = 2'd1,
      DIGIT   = 2'd2,
      ILLEGAL = 2'd3
   } frame_class_e;

   typedef struct packed {
      frame_class_e cls;
      logic [3:0]   val;
   } frame_info_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low gfedcba patterns; entry 0 sits in the low slice.
   localparam logic [15:0][6:0] DIGIT_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic frame_info_t classify_frame(input logic [7:0] frame);
      frame_info_t info;
      logic [2:0]  pos;
      logic [3:0]  idx;
      logic        hit;
      int          zeros;
      pos   = '0;
      idx   = '0;
      hit   = 1'b0;
      zeros = 0;
      for (int i = 0; i < 7; i++) begin
         if (!frame[i]) begin
            zeros++;
            pos = 3'(i);
         end
      end
      for (int j = 0; j < 16; j++) begin
         if (!hit && frame[6:0] == DIGIT_TABLE[j]) begin
            hit = 1'b1;
            idx = 4'(j);
         end
      end
      info.cls = ILLEGAL;
      info.val = '0;
      if (frame[7]) begin
         if (frame[6:0] == SEG_BLANK) begin
            info.cls = BLANK;
         end else if (zeros == 1) begin
            info.cls = MOLE;
            info.val = {1'b0, pos};
         end
      end else if (hit) begin
         info.cls = DIGIT;
         info.val = idx;
      end
      return info;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg_stable_filter.sv
// +--------------------------------------------------------------------+
// | seg_stable_filter : pin synchroniser plus run-length filter that   |
// |                     strobes each distinct stable frame once        |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seg_stable_filter
   import seg_dec_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] frame_in,
   output logic [7:0] frame_out,
   output logic       accept
);

   localparam int              CW      = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [7:0]      RST_FRM = {1'b1, SEG_BLANK};

   logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
   logic [7:0]                  cand_q, cand_d;
   logic [7:0]                  last_q, last_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        accept_q, accept_d;
   logic [7:0]                  frame_s;

   assign frame_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], frame_in};
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      accept_d = 1'b0;
      if (frame_s != cand_q) begin
         cand_d = frame_s;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Remembering the last accepted frame is what makes each frame fire once.
      if (cnt_q == CNT_MAX && frame_s == cand_q && cand_q != last_q) begin
         accept_d = 1'b1;
         last_d   = cand_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= {SYNC_STAGES{RST_FRM}};
         cand_q   <= RST_FRM;
         last_q   <= RST_FRM;
         cnt_q    <= '0;
         accept_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cand_q   <= cand_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         accept_q <= accept_d;
      end
   end

   assign frame_out = last_q;
   assign accept    = accept_q;

endmodule

`default_nettype wire

// File: rtl/seg_frame_decoder.sv
// +--------------------------------------------------------------------+
// | seg_frame_decoder : recovers game state from the active-low        |
// |                     7-segment bus; SEG_DECODE_ERR_COUNT_EN adds    |
// |                     a saturating illegal-frame counter             |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seg_frame_decoder
   import seg_dec_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic       dp_in,
   output logic [2:0] mole_pos,
   output logic       mole_valid,
   output logic       mole_change,
   output logic [7:0] mole_count,
   output logic       game_start,
   output logic       game_over,
   output logic [3:0] score_nib,
   output logic       score_valid,
   output logic       frame_err,
   output logic [7:0] err_cnt
);

   logic [7:0]  frame;
   logic        accept;
   frame_info_t info;

   dec_state_e  state_q, state_d;
   logic [2:0]  mole_pos_q, mole_pos_d;
   logic        mole_valid_q, mole_valid_d;
   logic        mole_change_q, mole_change_d;
   logic [7:0]  mole_count_q, mole_count_d;
   logic        game_start_q, game_start_d;
   logic        game_over_q, game_over_d;
   logic [3:0]  score_nib_q, score_nib_d;
   logic        score_valid_q, score_valid_d;
   logic        frame_err_q, frame_err_d;

   seg_stable_filter #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
   ) u_filter (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_in  ({dp_in, seg_in}),
      .frame_out (frame),
      .accept    (accept)
   );

   assign info = classify_frame(frame);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SYNC;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (info.cls == MOLE)       state_d = PLAY;
         else if (info.cls == DIGIT) state_d = OVER;
      end
   end

   always_comb begin
      mole_pos_d    = mole_pos_q;
      mole_valid_d  = mole_valid_q;
      mole_count_d  = mole_count_q;
      score_nib_d   = score_nib_q;
      score_valid_d = score_valid_q;
      mole_change_d = 1'b0;
      game_start_d  = 1'b0;
      game_over_d   = 1'b0;
      frame_err_d   = 1'b0;
      if (accept) begin
         unique case (info.cls)
            BLANK: mole_valid_d = 1'b0;
            MOLE: begin
               mole_pos_d    = info.val[2:0];
               mole_valid_d  = 1'b1;
               mole_change_d = 1'b1;
               if (state_q != PLAY) begin
                  game_start_d  = 1'b1;
                  mole_count_d  = 8'd1;
                  score_valid_d = 1'b0;
               end else if (mole_count_q != 8'hFF) begin
                  mole_count_d = mole_count_q + 8'd1;
               end
            end
            DIGIT: begin
               score_nib_d   = info.val;
               score_valid_d = 1'b1;
               mole_valid_d  = 1'b0;
               // A score seen straight out of reset is a resync, not an ending.
               game_over_d   = (state_q == PLAY);
            end
            default: frame_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mole_pos_q    <= '0;
         mole_valid_q  <= 1'b0;
         mole_change_q <= 1'b0;
         mole_count_q  <= '0;
         game_start_q  <= 1'b0;
         game_over_q   <= 1'b0;
         score_nib_q   <= '0;
         score_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         mole_pos_q    <= mole_pos_d;
         mole_valid_q  <= mole_valid_d;
         mole_change_q <= mole_change_d;
         mole_count_q  <= mole_count_d;
         game_start_q  <= game_start_d;
         game_over_q   <= game_over_d;
         score_nib_q   <= score_nib_d;
         score_valid_q <= score_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

`ifdef SEG_DECODE_ERR_COUNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (frame_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 8'h00;
`endif

   assign mole_pos    = mole_pos_q;
   assign mole_valid  = mole_valid_q;
   assign mole_change = mole_change_q;
   assign mole_count  = mole_count_q;
   assign game_start  = game_start_q;
   assign game_over   = game_over_q;
   assign score_nib   = score_nib_q;
   assign score_valid = score_valid_q;
   assign frame_err   = frame_err_q;

endmodule

`default_nettype wire
